// File: rtl/pop_sequencer.sv
// Stack POP micro-sequencer: two byte reads from SP and SP+1, each followed by an SP
// increment, then a single register-pair write and hand-off to opcode fetch.
module pop_sequencer (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [1:0]  i_P,
    input  logic [15:0] i_SP,
    input  logic [7:0]  i_Bus_Data,
    input  logic        i_Stall,
    output logic [15:0] o_Address,
    output logic        o_Address_Out,
    output logic        o_Mem_Read,
    output logic [15:0] o_SP_Next,
    output logic        o_SP_Write,
    output logic [15:0] o_Reg_Data,
    output logic [1:0]  o_Reg_Sel,
    output logic        o_Reg_Write,
    output logic        o_IR_Fetch,
    output logic        o_Busy,
    output logic [3:0]  o_Cycle_Step
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_LO = 2'd1,
        READ_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] STEP_1 = 4'b0001;
    localparam logic [3:0] STEP_2 = 4'b0010;
    localparam logic [3:0] STEP_3 = 4'b0100;
    localparam logic [3:0] STEP_4 = 4'b1000;

    state_t      state, state_n;
    logic [3:0]  step_n;
    logic [15:0] ptr, ptr_n;
    logic [7:0]  lo_byte, lo_n;
    logic [7:0]  hi_byte, hi_n;
    logic [1:0]  sel_n;

    logic [15:0] address_n;
    logic        address_out_n;
    logic        mem_read_n;
    logic [15:0] sp_next_n;
    logic        sp_write_n;
    logic [15:0] reg_data_n;
    logic        reg_write_n;
    logic        ir_fetch_n;
    logic        busy_n;

    // Next-state: sequencing advances only on non-stalled edges.
    always_comb begin
        state_n = state;
        step_n  = o_Cycle_Step;
        ptr_n   = ptr;
        lo_n    = lo_byte;
        hi_n    = hi_byte;
        sel_n   = o_Reg_Sel;
        if (!i_Stall) begin
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        ptr_n   = i_SP;
                        sel_n   = i_P;
                        state_n = READ_LO;
                        step_n  = STEP_1;
                    end
                end
                READ_LO, READ_HI: begin
                    case (o_Cycle_Step)
                        STEP_1: step_n = STEP_2;
                        STEP_2: begin
                            if (state == READ_LO) lo_n = i_Bus_Data;
                            else                  hi_n = i_Bus_Data;
                            step_n = STEP_3;
                        end
                        STEP_3: begin
                            ptr_n  = ptr + 16'd1;
                            step_n = STEP_4;
                        end
                        default: begin
                            step_n  = STEP_1;
                            state_n = (state == READ_LO) ? READ_HI : DONE;
                        end
                    endcase
                end
                default: begin
                    state_n = IDLE;
                    step_n  = STEP_1;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they can be registered.
    always_comb begin
        address_n     = 16'd0;
        address_out_n = 1'b0;
        mem_read_n    = 1'b0;
        sp_next_n     = 16'd0;
        sp_write_n    = 1'b0;
        reg_data_n    = 16'd0;
        reg_write_n   = 1'b0;
        ir_fetch_n    = 1'b0;
        busy_n        = (state_n != IDLE);
        if (state_n == READ_LO || state_n == READ_HI) begin
            case (step_n)
                STEP_1: begin
                    address_n     = ptr_n;
                    address_out_n = 1'b1;
                end
                STEP_2: begin
                    address_n     = ptr_n;
                    address_out_n = 1'b1;
                    mem_read_n    = 1'b1;
                end
                STEP_3: begin
                    sp_next_n  = ptr_n + 16'd1;
                    sp_write_n = 1'b1;
                end
                default: ;
            endcase
        end else if (state_n == DONE) begin
            reg_write_n = 1'b1;
            ir_fetch_n  = 1'b1;
            // The flag register of AF has no storage in its low nibble.
            reg_data_n  = {hi_n, (sel_n == 2'b11) ? {lo_n[7:4], 4'b0000} : lo_n};
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= IDLE;
            o_Cycle_Step  <= STEP_1;
            ptr           <= 16'd0;
            lo_byte       <= 8'd0;
            hi_byte       <= 8'd0;
            o_Reg_Sel     <= 2'b00;
            o_Address     <= 16'd0;
            o_Address_Out <= 1'b0;
            o_Mem_Read    <= 1'b0;
            o_SP_Next     <= 16'd0;
            o_SP_Write    <= 1'b0;
            o_Reg_Data    <= 16'd0;
            o_Reg_Write   <= 1'b0;
            o_IR_Fetch    <= 1'b0;
            o_Busy        <= 1'b0;
        end else if (!i_Stall) begin
            state         <= state_n;
            o_Cycle_Step  <= step_n;
            ptr           <= ptr_n;
            lo_byte       <= lo_n;
            hi_byte       <= hi_n;
            o_Reg_Sel     <= sel_n;
            o_Address     <= address_n;
            o_Address_Out <= address_out_n;
            o_Mem_Read    <= mem_read_n;
            o_SP_Next     <= sp_next_n;
            o_SP_Write    <= sp_write_n;
            o_Reg_Data    <= reg_data_n;
            o_Reg_Write   <= reg_write_n;
            o_IR_Fetch    <= ir_fetch_n;
            o_Busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_pop_sequencer.sv
// Directed and randomized POP transactions checked cycle by cycle against a
// timeline model derived from the clock offset since start.
module tb_pop_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Start;
    logic [1:0]  i_P;
    logic [15:0] i_SP;
    logic [7:0]  i_Bus_Data;
    logic        i_Stall;
    logic [15:0] o_Address;
    logic        o_Address_Out;
    logic        o_Mem_Read;
    logic [15:0] o_SP_Next;
    logic        o_SP_Write;
    logic [15:0] o_Reg_Data;
    logic [1:0]  o_Reg_Sel;
    logic        o_Reg_Write;
    logic        o_IR_Fetch;
    logic        o_Busy;
    logic [3:0]  o_Cycle_Step;

    int n_checks = 0;
    int n_fail   = 0;
    int regw_cnt = 0;

    pop_sequencer dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_P(i_P), .i_SP(i_SP),
        .i_Bus_Data(i_Bus_Data), .i_Stall(i_Stall), .o_Address(o_Address),
        .o_Address_Out(o_Address_Out), .o_Mem_Read(o_Mem_Read), .o_SP_Next(o_SP_Next),
        .o_SP_Write(o_SP_Write), .o_Reg_Data(o_Reg_Data), .o_Reg_Sel(o_Reg_Sel),
        .o_Reg_Write(o_Reg_Write), .o_IR_Fetch(o_IR_Fetch), .o_Busy(o_Busy),
        .o_Cycle_Step(o_Cycle_Step)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) if (o_Reg_Write === 1'b1) regw_cnt++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".addr"}, o_Address, 16'd0);
        chk({tag, ".aout"}, {15'd0, o_Address_Out}, 16'd0);
        chk({tag, ".rd"},   {15'd0, o_Mem_Read}, 16'd0);
        chk({tag, ".spn"},  o_SP_Next, 16'd0);
        chk({tag, ".spw"},  {15'd0, o_SP_Write}, 16'd0);
        chk({tag, ".data"}, o_Reg_Data, 16'd0);
        chk({tag, ".regw"}, {15'd0, o_Reg_Write}, 16'd0);
        chk({tag, ".irf"},  {15'd0, o_IR_Fetch}, 16'd0);
        chk({tag, ".busy"}, {15'd0, o_Busy}, 16'd0);
        chk({tag, ".step"}, {12'd0, o_Cycle_Step}, 16'd1);
    endtask

    // Expected outputs k clocks (non-stalled) after the clock that sampled start.
    task automatic chk_timeline(input int k, input logic [15:0] sp, input logic [1:0] p,
                                input logic [7:0] lo, input logic [7:0] hi);
        int phase, t;
        logic [15:0] a, e_addr, e_spn, e_data;
        logic e_aout, e_rd, e_spw;
        phase = (k - 1) / 4;
        t     = (k - 1) % 4;
        a     = sp + 16'(phase);
        if (k >= 10) begin
            chk_idle_zero("idle");
            chk("idle.sel", {14'd0, o_Reg_Sel}, {14'd0, p});
        end else if (k == 9) begin
            e_data = {hi, (p == 2'b11) ? (lo & 8'hF0) : lo};
            chk("done.data", o_Reg_Data, e_data);
            chk("done.regw", {15'd0, o_Reg_Write}, 16'd1);
            chk("done.irf",  {15'd0, o_IR_Fetch}, 16'd1);
            chk("done.busy", {15'd0, o_Busy}, 16'd1);
            chk("done.sel",  {14'd0, o_Reg_Sel}, {14'd0, p});
            chk("done.addr", {o_Address[15:1], o_Address_Out ^ o_Mem_Read ^ o_SP_Write}, 16'd0);
        end else begin
            e_aout = (t < 2);
            e_rd   = (t == 1);
            e_spw  = (t == 2);
            e_addr = e_aout ? a : 16'd0;
            e_spn  = e_spw ? a + 16'd1 : 16'd0;
            chk($sformatf("k%0d.step", k), {12'd0, o_Cycle_Step}, 16'd1 << t);
            chk($sformatf("k%0d.addr", k), o_Address, e_addr);
            chk($sformatf("k%0d.aout", k), {15'd0, o_Address_Out}, {15'd0, e_aout});
            chk($sformatf("k%0d.rd", k),   {15'd0, o_Mem_Read}, {15'd0, e_rd});
            chk($sformatf("k%0d.spw", k),  {15'd0, o_SP_Write}, {15'd0, e_spw});
            chk($sformatf("k%0d.spn", k),  o_SP_Next, e_spn);
            chk($sformatf("k%0d.regw", k), {15'd0, o_Reg_Write | o_IR_Fetch}, 16'd0);
            chk($sformatf("k%0d.data", k), o_Reg_Data, 16'd0);
            chk($sformatf("k%0d.busy", k), {15'd0, o_Busy}, 16'd1);
            chk($sformatf("k%0d.sel", k),  {14'd0, o_Reg_Sel}, {14'd0, p});
        end
    endtask

    // One POP; stall_k/stall_len inject a stall, reset_k aborts (0 disables).
    task automatic run_pop(input logic [15:0] sp, input logic [1:0] p,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input int stall_k, input int stall_len,
                           input bit repulse, input int reset_k);
        int k, cyc, stalls, base;
        bit stall_now;
        k = 1; cyc = 1; stalls = 0;
        base = regw_cnt;
        @(negedge i_Clk);
        i_SP = sp; i_P = p; i_Start = 1'b1; i_Stall = 1'b0;
        @(negedge i_Clk);
        i_Start = 1'b0;
        i_SP = 16'($urandom); i_P = 2'($urandom);
        while (k <= 10) begin
            chk_timeline(k, sp, p, lo, hi);
            if (k == 9) chk("latency", 16'(cyc), 16'(9 + stall_len));
            if (k == reset_k) begin
                i_Reset = 1'b1;
                #1;
                chk_idle_zero("abort");
                chk("abort.sel", {14'd0, o_Reg_Sel}, 16'd0);
                @(negedge i_Clk);
                i_Reset = 1'b0;
                chk("abort.regw_cnt", 16'(regw_cnt - base), 16'd0);
                return;
            end
            if (k == 10) break;
            stall_now  = (k == stall_k) && (stalls < stall_len);
            i_Stall    = stall_now;
            i_Bus_Data = 8'($urandom);
            if (!stall_now && k == 2) i_Bus_Data = lo;
            if (!stall_now && k == 6) i_Bus_Data = hi;
            i_Start    = repulse && (k == 3 || k == 9);
            @(negedge i_Clk);
            cyc++;
            if (stall_now) stalls++;
            else k++;
        end
        i_Start = 1'b0;
        i_Stall = 1'b0;
        chk("pop.regw_cnt", 16'(regw_cnt - base), 16'd1);
    endtask

    initial begin
        i_Reset = 1'b1; i_Start = 1'b0; i_P = 2'b00; i_SP = 16'd0;
        i_Bus_Data = 8'd0; i_Stall = 1'b0;
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        chk_idle_zero("reset");
        chk("reset.sel", {14'd0, o_Reg_Sel}, 16'd0);
        i_Start = 1'b0;
        i_Reset = 1'b0;

        run_pop(16'hC000, 2'b00, 8'h34, 8'h12, 0, 0, 1'b0, 0);
        run_pop(16'h8000, 2'b11, 8'hFF, 8'hAB, 0, 0, 1'b0, 0);
        run_pop(16'hFFFF, 2'b01, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 0);
        run_pop(16'($urandom), 2'b10, 8'($urandom), 8'($urandom), 2, 3, 1'b0, 0);
        run_pop(16'($urandom), 2'b01, 8'($urandom), 8'($urandom), 0, 0, 1'b1, 0);
        run_pop(16'($urandom), 2'b00, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 7);
        run_pop(16'hD000, 2'b10, 8'($urandom), 8'($urandom), 0, 0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            run_pop(16'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 8)), int'($urandom_range(0, 4)),
                    1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
